delta_gen_seq: RTL and testbench
================================

Name: delta_gen_seq

Overview:
- Sequential, parametrised backprop error-term (delta) generator for the FFNN accelerator; successor of the single-neuron combinational delta path.
- On a start pulse, walks every neuron of one layer and computes its delta:
  - Output layer: y − desired.
  - Hidden layer: Σ wT·d_next, as a serial MAC over a synchronous weight-memory read port.
- Applies the leaky-ReLU derivative, then streams one delta per neuron over a valid/ready interface into the delta buffer.

Parameters:
- WIDTH, 32, data word width; sign-magnitude fixed point, bit WIDTH-1 is the sign (same format as qadd/qmult).
- FRAC, 16, fractional bits.
- N_NEURONS, 8, neurons in the current layer; max 256.
- N_NEXT, 8, neurons in the next layer (MAC length).
- MAX_DEPTH, 4, number of layers; layer MAX_DEPTH-1 is the output layer.
- LEAKY_SLOPE, 32'h0000_4000, leaky-ReLU negative slope in the same format (0.25 at FRAC=16).

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST_N  in  1  synchronous reset, active-low.
- start  in  1  one-cycle request; accepted only in IDLE.
- layer_index  in  8  layer to process; sampled when start is accepted.
- y_out  in  N_NEURONS*WIDTH  layer outputs; neuron i at bits [i*WIDTH +: WIDTH].
- desired  in  N_NEURONS*WIDTH  targets; used only for the output layer.
- d_in  in  N_NEXT*WIDTH  next-layer deltas; used only for hidden layers.
- w_addr  out  clog2(N_NEURONS*N_NEXT)  transposed-weight address = i*N_NEXT + k.
- w_en  out  1  weight read enable.
- w_rdata  in  WIDTH  weight data; valid exactly 1 cycle after w_en.
- d_valid  out  1  delta available.
- d_ready  in  1  downstream accepts the delta.
- d_index  out  8  neuron index of d_data.
- d_data  out  WIDTH  delta value.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse at end of layer.
- err  out  1  sticky; set on invalid layer_index, cleared at next accepted start.

Behaviour:
- Reset (RST_N=0 at an edge): state IDLE; busy, done, err, d_valid, w_en = 0; d_data, d_index, w_addr, accumulator, counters = 0.
  - Reset mid-layer aborts immediately; no done pulse.
- Inputs y_out, desired, d_in must be stable while busy; they are not registered.
- IDLE: on start, latch layer_index, set busy, clear err, i=0.
  - layer_index >= MAX_DEPTH: go to DONE with err=1; no deltas emitted.
  - layer_index == MAX_DEPTH-1: go to OUT_CALC.
  - Otherwise go to MAC.
  - start while busy is ignored.
- OUT_CALC (1 cycle): raw = qadd(y[i], desired[i] with sign bit flipped). Go to SCALE.
- MAC:
  - Cycles k=0..N_NEXT-1 issue w_en=1, w_addr=i*N_NEXT+k.
  - Each returned w_rdata is multiplied by d_in[k] (qmult: magnitude product >> FRAC, sign = XOR) and added into the accumulator.
  - Last product is accumulated N_NEXT+1 cycles after MAC entry; then raw = acc, acc cleared, go to SCALE.
- SCALE (1 cycle):
  - If y[i] sign bit = 1: d = qmult(raw, LEAKY_SLOPE); else d = raw.
  - Register d_data=d, d_index=i, d_valid=1; go to EMIT.
- EMIT: hold d_valid, d_data, d_index stable until d_ready=1 at an edge.
  - On transfer: if i==N_NEURONS-1 go to DONE, else i++ and return to OUT_CALC/MAC.
  - d_ready high in the same cycle d_valid rises transfers in that cycle.
- DONE (1 cycle): done=1, busy=0, then IDLE. A start in the DONE cycle is ignored.
- Arithmetic rules:
  - All adds and multiplies saturate to magnitude 2^(WIDTH-1)-1, keeping the sign.
  - A zero magnitude result is always +0, i.e. sign 0 (no negative zero).
- Per-neuron latency with d_ready held high:
  - Output layer: 3 cycles.
  - Hidden layer: N_NEXT+3 cycles.
- Layer totals (start to done): N_NEURONS*per-neuron + 2.

Test Plan:
- Output layer, WIDTH=32, FRAC=16, layer_index=3: y[0]=0x0001_8000 (1.5), desired[0]=0x0002_0000 → d_index=0, d_data=0x8000_8000 (−0.5, no leak).
- Output layer, negative y: y[0]=0x8001_0000, desired[0]=0x0001_0000 → raw −2.0, leak ×0.25 → d_data=0x8000_8000; with d_ready held low 5 cycles, d_data/d_valid stay stable.
- Hidden layer, N_NEXT=2, layer_index=1: w=[0x0001_0000, 0x0002_0000], d_in=[0x0000_8000, 0x8000_4000], y positive → d_data=0x0000_0000 (+0, sign clear); w_en high exactly 2 cycles per neuron with addresses i*2, i*2+1.
- Full layer of N_NEURONS=8 with d_ready=1: 8 transfers with d_index 0..7 in order, done one cycle after the last transfer, busy low afterwards; a start pulsed while busy changes nothing.
- Saturation: y=0x7FFF_0000, desired=0x8001_0000 → d_data=0x7FFF_FFFF.
- layer_index=4 → no d_valid, done pulse 2 cycles after start, err=1. RST_N low mid-MAC → next edge all outputs 0, no done pulse.

Source files
------------

// File: rtl/delta_gen_seq_if.sv
// delta_gen_seq_if: weight read port and delta stream between delta_gen_seq and its memory/buffer
//   w_addr/w_en -> weight address and read enable, w_rdata <- weight word one cycle after w_en
//   d_valid/d_index/d_data -> delta stream, d_ready <- downstream accept
interface delta_gen_seq_if #(
  parameter int WIDTH = 32,
  parameter int AW = 6
);
  logic [AW-1:0] w_addr;
  logic w_en;
  logic [WIDTH-1:0] w_rdata;
  logic d_valid;
  logic d_ready;
  logic [7:0] d_index;
  logic [WIDTH-1:0] d_data;
  modport master (output w_addr, w_en, d_valid, d_index, d_data, input w_rdata, d_ready);
  modport slave (input w_addr, w_en, d_valid, d_index, d_data, output w_rdata, d_ready);
endinterface

// File: rtl/delta_gen_seq.sv
// delta_gen_seq: per-layer backprop delta generator (output error or serial wT*d MAC, leaky-ReLU derivative)
//   CLK/RST_N: clock, synchronous active-low reset
//   i_start/i_layer_index: layer request; i_y_out/i_desired/i_d_in: layer operands, held stable while busy
//   bus: weight read port and delta stream; o_busy/o_done/o_err: status
module delta_gen_seq #(
  parameter int WIDTH = 32,
  parameter int FRAC = 16,
  parameter int N_NEURONS = 8,
  parameter int N_NEXT = 8,
  parameter int MAX_DEPTH = 4,
  parameter logic [WIDTH-1:0] LEAKY_SLOPE = WIDTH'(32'h0000_4000)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic i_start,
  input  logic [7:0] i_layer_index,
  input  logic [N_NEURONS*WIDTH-1:0] i_y_out,
  input  logic [N_NEURONS*WIDTH-1:0] i_desired,
  input  logic [N_NEXT*WIDTH-1:0] i_d_in,
  delta_gen_seq_if.master bus,
  output logic o_busy,
  output logic o_done,
  output logic o_err
);
  localparam int AW = $clog2(N_NEURONS*N_NEXT);
  localparam int KW = $clog2(N_NEXT+1);
  localparam logic [KW-1:0] K_LAST = KW'(N_NEXT);
  localparam logic [7:0] I_LAST = 8'(N_NEURONS-1);
  localparam logic [8:0] DEPTH = 9'(MAX_DEPTH);
  localparam logic [7:0] OUT_LAYER = 8'(MAX_DEPTH-1);
  typedef enum logic [2:0] {IDLE, OUT_CALC, MAC, SCALE, EMIT, DONE} state_t;
  // Sign-magnitude saturating add; a zero result is forced to +0
  function automatic logic [WIDTH-1:0] qadd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] s;
    logic [WIDTH-2:0] m;
    logic same, a_big, sg;
    same = a[WIDTH-1] == b[WIDTH-1];
    a_big = a[WIDTH-2:0] >= b[WIDTH-2:0];
    s = {1'b0, a[WIDTH-2:0]} + {1'b0, b[WIDTH-2:0]};
    m = same ? (s[WIDTH-1] ? '1 : s[WIDTH-2:0]) : a_big ? a[WIDTH-2:0] - b[WIDTH-2:0] : b[WIDTH-2:0] - a[WIDTH-2:0];
    sg = same || a_big ? a[WIDTH-1] : b[WIDTH-1];
    return {sg & |m, m};
  endfunction
  // Sign-magnitude saturating multiply, product magnitude rescaled by FRAC
  function automatic logic [WIDTH-1:0] qmult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-3:0] p;
    logic [WIDTH-2:0] m;
    p = {{(WIDTH-1){1'b0}}, a[WIDTH-2:0]} * {{(WIDTH-1){1'b0}}, b[WIDTH-2:0]};
    p = p >> FRAC;
    m = |p[2*WIDTH-3:WIDTH-1] ? '1 : p[WIDTH-2:0];
    return {(a[WIDTH-1] ^ b[WIDTH-1]) & |m, m};
  endfunction
  state_t r_state, w_next;
  logic [7:0] r_i;
  logic [KW-1:0] r_k;
  logic [WIDTH-1:0] r_acc, r_raw, r_data;
  logic r_out, r_err;
  logic [KW-1:0] w_kidx;
  logic [WIDTH-1:0] w_y, w_des, w_dk, w_prod, w_sum, w_diff;
  // Read data lags the address by one cycle, so MAC step k consumes the product of k-1
  assign w_kidx = r_k == '0 ? '0 : r_k - 1'b1;
  assign w_y = i_y_out[r_i*WIDTH +: WIDTH];
  assign w_des = i_desired[r_i*WIDTH +: WIDTH];
  assign w_dk = i_d_in[w_kidx*WIDTH +: WIDTH];
  assign w_prod = qmult(bus.w_rdata, w_dk);
  assign w_sum = qadd(r_acc, w_prod);
  assign w_diff = qadd(w_y, {~w_des[WIDTH-1], w_des[WIDTH-2:0]});
  assign bus.w_en = r_state == MAC && r_k != K_LAST;
  assign bus.w_addr = bus.w_en ? AW'(int'(r_i)*N_NEXT + int'(r_k)) : '0;
  assign bus.d_valid = r_state == EMIT;
  assign bus.d_index = r_i;
  assign bus.d_data = r_data;
  assign o_busy = r_state != IDLE && r_state != DONE;
  assign o_done = r_state == DONE;
  assign o_err = r_err;
  always_ff @(posedge CLK)
    if (!RST_N) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !i_start ? IDLE : {1'b0, i_layer_index} >= DEPTH ? DONE : i_layer_index == OUT_LAYER ? OUT_CALC : MAC;
      OUT_CALC: w_next = SCALE;
      MAC: w_next = r_k == K_LAST ? SCALE : MAC;
      SCALE: w_next = EMIT;
      EMIT: w_next = !bus.d_ready ? EMIT : r_i == I_LAST ? DONE : r_out ? OUT_CALC : MAC;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_i <= '0;
      r_k <= '0;
      r_acc <= '0;
      r_raw <= '0;
      r_data <= '0;
      r_out <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (r_state == IDLE && i_start) begin
        r_err <= {1'b0, i_layer_index} >= DEPTH;
        r_out <= i_layer_index == OUT_LAYER;
        r_i <= '0;
        r_k <= '0;
        r_acc <= '0;
      end
      if (r_state == OUT_CALC) r_raw <= w_diff;
      if (r_state == MAC) begin
        r_k <= r_k == K_LAST ? '0 : r_k + 1'b1;
        r_acc <= r_k == K_LAST ? '0 : r_k == '0 ? r_acc : w_sum;
        if (r_k == K_LAST) r_raw <= w_sum;
      end
      if (r_state == SCALE) r_data <= w_y[WIDTH-1] ? qmult(r_raw, LEAKY_SLOPE) : r_raw;
      if (r_state == EMIT && bus.d_ready) r_i <= r_i == I_LAST ? '0 : r_i + 8'd1;
    end
  end
endmodule

// File: tb/tb_delta_gen_seq.sv
// tb_delta_gen_seq: directed self-checking bench for delta_gen_seq (8 neurons, N_NEXT=2)
module tb_delta_gen_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_start = 1'b0;
  logic [7:0] i_layer_index = '0;
  logic [255:0] y_out = '0;
  logic [255:0] desired = '0;
  logic [63:0] d_in = '0;
  logic o_busy, o_done, o_err;
  logic [31:0] mem [16];
  int checks = 0;
  int failures = 0;
  int n_xfer, n_w, n_stall, done_cyc;
  int xcyc [16];
  logic [31:0] xdat [16];
  logic [7:0] xidx [16];
  logic [3:0] waddr [32];
  int wcyc [32];
  logic [31:0] sdat [16];
  logic [31:0] exp_d [8];
  delta_gen_seq_if #(.WIDTH(32), .AW(4)) bus ();
  delta_gen_seq #(.N_NEXT(2)) dut (
    .CLK(clk), .RST_N(rst_n), .i_start(i_start), .i_layer_index(i_layer_index),
    .i_y_out(y_out), .i_desired(desired), .i_d_in(d_in), .bus(bus),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.w_en) bus.w_rdata <= mem[bus.w_addr];
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_layer(input logic [7:0] li, input int stall);
    n_xfer = 0; n_w = 0; n_stall = 0; done_cyc = -1;
    bus.d_ready = 1'b1;
    i_layer_index = li;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      if (c == 1) chk("busy_after_start", 32'(o_busy), 32'(li < 8'd4));
      if (o_done) done_cyc = c;
      if (bus.w_en && n_w < 32) begin waddr[n_w] = bus.w_addr; wcyc[n_w] = c; end
      if (bus.w_en) n_w++;
      if (bus.d_valid && stall > 0) begin
        bus.d_ready = 1'b0;
        if (n_stall < 16) sdat[n_stall] = bus.d_data;
        n_stall++;
        stall--;
      end else bus.d_ready = 1'b1;
      if (bus.d_valid && bus.d_ready) begin
        if (n_xfer < 16) begin xidx[n_xfer] = bus.d_index; xdat[n_xfer] = bus.d_data; xcyc[n_xfer] = c; end
        n_xfer++;
      end
      i_start = c == 2;
      tick;
    end
    i_start = 1'b0;
    bus.d_ready = 1'b1;
  endtask
  task automatic check_xfers(input int per, input int off);
    chk("xfer_count", n_xfer, 8);
    for (int j = 0; j < 8 && j < n_xfer; j++) begin
      chk("d_index", 32'(xidx[j]), j);
      chk("d_data", xdat[j], exp_d[j]);
      chk("xfer_cycle", xcyc[j], per*(j+1) + off);
    end
    chk("done_cycle", done_cyc, 8*per + 1 + off);
    chk("busy_after_done", 32'(o_busy), 0);
    chk("done_pulse_width", 32'(o_done), 0);
  endtask
  initial begin
    for (int a = 0; a < 16; a++) mem[a] = '0;
    mem[0] = 32'h0001_0000; mem[1] = 32'h0002_0000; mem[2] = 32'h0001_0000; mem[4] = 32'h0004_0000;
    bus.d_ready = 1'b1;
    repeat (3) tick;
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    chk("rst_valid", 32'(bus.d_valid), 0);
    chk("rst_w_en", 32'(bus.w_en), 0);
    chk("rst_w_addr", 32'(bus.w_addr), 0);
    chk("rst_d_data", bus.d_data, 0);
    chk("rst_d_index", 32'(bus.d_index), 0);
    rst_n = 1'b1;
    tick;
    for (int j = 1; j < 8; j++) begin
      y_out[j*32 +: 32] = 32'(j) << 16;
      exp_d[j] = 32'(j) << 16;
    end
    y_out[31:0] = 32'h0001_8000; desired[31:0] = 32'h0002_0000; exp_d[0] = 32'h8000_8000;
    run_layer(8'd3, 0);
    check_xfers(3, 0);
    chk("out_no_w_en", n_w, 0);
    chk("out_err", 32'(o_err), 0);
    y_out[31:0] = 32'h8001_0000; desired[31:0] = 32'h0001_0000; exp_d[0] = 32'h8000_8000;
    run_layer(8'd3, 5);
    check_xfers(3, 5);
    chk("stall_cycles", n_stall, 5);
    for (int s = 0; s < 5 && s < n_stall; s++) chk("stall_data", sdat[s], 32'h8000_8000);
    y_out[31:0] = 32'h7FFF_0000; desired[31:0] = 32'h8001_0000; exp_d[0] = 32'h7FFF_FFFF;
    run_layer(8'd3, 0);
    chk("sat_data", xdat[0], 32'h7FFF_FFFF);
    desired = '0;
    for (int j = 0; j < 8; j++) begin
      y_out[j*32 +: 32] = 32'h0001_0000;
      exp_d[j] = 32'h0;
    end
    y_out[2*32 +: 32] = 32'h8001_0000;
    exp_d[1] = 32'h0000_8000; exp_d[2] = 32'h0000_8000;
    d_in = {32'h8000_4000, 32'h0000_8000};
    run_layer(8'd1, 0);
    check_xfers(5, 0);
    chk("w_en_count", n_w, 16);
    for (int j = 0; j < 16 && j < n_w; j++) begin
      chk("w_addr", 32'(waddr[j]), j);
      chk("w_cycle", wcyc[j], 5*(j/2) + 1 + j%2);
    end
    run_layer(8'd4, 0);
    chk("bad_done_cycle", done_cyc, 1);
    chk("bad_no_xfer", n_xfer, 0);
    chk("bad_no_w_en", n_w, 0);
    chk("bad_err", 32'(o_err), 1);
    tick;
    chk("err_sticky", 32'(o_err), 1);
    i_layer_index = 8'd1;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("err_cleared", 32'(o_err), 0);
    chk("mac_w_en", 32'(bus.w_en), 1);
    tick;
    chk("mac_w_addr", 32'(bus.w_addr), 1);
    rst_n = 1'b0;
    tick;
    chk("abort_busy", 32'(o_busy), 0);
    chk("abort_done", 32'(o_done), 0);
    chk("abort_w_en", 32'(bus.w_en), 0);
    chk("abort_w_addr", 32'(bus.w_addr), 0);
    chk("abort_valid", 32'(bus.d_valid), 0);
    chk("abort_d_data", bus.d_data, 0);
    rst_n = 1'b1;
    tick;
    chk("abort_no_done", 32'(o_done), 0);
    chk("abort_idle", 32'(o_busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
